// File: rtl/sr_drive_ctrl.sv
// Command sequencer for a downstream SR flip-flop: pulses S or R for a
// programmable width, lets the latch settle, then verifies the fed-back Q.
module sr_drive_ctrl #(
  parameter int unsigned CHECK_WAIT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_op,
  input  logic [3:0] req_len,
  output logic       s,
  output logic       r,
  input  logic       q_fb,
  output logic       done,
  output logic       err,
  output logic [7:0] mismatch_cnt
);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  localparam logic [1:0] OP_HOLD  = 2'b00;
  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_RESET = 2'b10;
  localparam logic [3:0] SETTLE_LAST = 4'(CHECK_WAIT - 1);

  state_t     r_state, w_state_n;
  logic [3:0] r_cnt, w_cnt_n;
  logic       r_exp, w_exp_n;
  logic       r_s, w_s_n;
  logic       r_r, w_r_n;
  logic       r_done, w_done_n;
  logic       r_err, w_err_n;
  logic       r_ready, w_ready_n;
  logic [7:0] r_mis, w_mis_n;
  logic       w_xfer;

  assign w_xfer = req_valid && r_ready;

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_exp_n   = r_exp;
    w_s_n     = 1'b0;
    w_r_n     = 1'b0;
    w_done_n  = 1'b0;
    w_err_n   = 1'b0;
    w_mis_n   = r_mis;
    unique case (r_state)
      IDLE: begin
        if (w_xfer) begin
          // r_cnt holds the remaining DRIVE cycles minus one
          w_cnt_n = (req_len == 4'd0) ? 4'd0 : req_len - 4'd1;
          unique case (req_op)
            OP_HOLD: w_done_n = 1'b1;
            OP_SET: begin
              w_state_n = DRIVE;
              w_exp_n   = 1'b1;
              w_s_n     = 1'b1;
            end
            OP_RESET: begin
              w_state_n = DRIVE;
              w_exp_n   = 1'b0;
              w_r_n     = 1'b1;
            end
            default: w_err_n = 1'b1;
          endcase
        end
      end
      DRIVE: begin
        if (r_cnt == 4'd0) begin
          w_state_n = SETTLE;
          w_cnt_n   = SETTLE_LAST;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
          w_s_n   = r_exp;
          w_r_n   = !r_exp;
        end
      end
      SETTLE: begin
        if (r_cnt == 4'd0) begin
          w_state_n = CHECK;
        end else begin
          w_cnt_n = r_cnt - 4'd1;
        end
      end
      CHECK: begin
        w_state_n = IDLE;
        if (q_fb == r_exp) begin
          w_done_n = 1'b1;
        end else begin
          w_err_n = 1'b1;
          w_mis_n = (r_mis == 8'hFF) ? r_mis : r_mis + 8'd1;
        end
      end
      default: w_state_n = IDLE;
    endcase
    w_ready_n = (w_state_n == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_exp   <= 1'b0;
      r_s     <= 1'b0;
      r_r     <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ready <= 1'b0;
      r_mis   <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_exp   <= w_exp_n;
      r_s     <= w_s_n;
      r_r     <= w_r_n;
      r_done  <= w_done_n;
      r_err   <= w_err_n;
      r_ready <= w_ready_n;
      r_mis   <= w_mis_n;
    end
  end

  assign req_ready    = r_ready;
  assign s            = r_s;
  assign r            = r_r;
  assign done         = r_done;
  assign err          = r_err;
  assign mismatch_cnt = r_mis;

endmodule

// File: tb/tb_sr_drive_ctrl.sv
// Self-checking bench for sr_drive_ctrl: directed scenarios plus randomized
// commands against a cycle-timeline model of the command protocol.
module tb_sr_drive_ctrl;

  localparam int unsigned W = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [3:0] req_len;
  logic       s;
  logic       r;
  logic       q_fb;
  logic       done;
  logic       err;
  logic [7:0] mismatch_cnt;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  int unsigned mis_model   = 0;

  // Downstream latch model; q_mode 0 = follows S/R, 1 = stuck low, 2 = stuck high
  logic q_ff   = 1'b0;
  int   q_mode = 0;

  sr_drive_ctrl #(.CHECK_WAIT(W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_len(req_len), .s(s), .r(r), .q_fb(q_fb),
    .done(done), .err(err), .mismatch_cnt(mismatch_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s === 1'b1) q_ff <= 1'b1;
    else if (r === 1'b1) q_ff <= 1'b0;
  end

  assign q_fb = (q_mode == 0) ? q_ff : (q_mode == 2);

  always @(negedge clk) begin
    vectors++;
    if (s === 1'b1 && r === 1'b1) begin
      miscompares++;
      $display("FAIL s_r_exclusive t=%0t s=%b r=%b required not both 1", $time, s, r);
    end
    vectors++;
    if (done === 1'b1 && err === 1'b1) begin
      miscompares++;
      $display("FAIL done_err_exclusive t=%0t done=%b err=%b required not both 1", $time, done, err);
    end
  end

  // Issues one command (caller sits 1 time unit after a rising edge with
  // req_ready high) and checks every cycle up to and including the result.
  task automatic run_cmd(input logic [1:0] op, input logic [3:0] len, input int qm);
    int   L, T;
    logic is_sr, exp_q, q_at_check, match;
    logic es, er, ed, ee, ery;
    is_sr      = (op == 2'b01) || (op == 2'b10);
    L          = (len == 4'd0) ? 1 : int'(len);
    T          = is_sr ? (1 + L + int'(W) + 1) : 1;
    exp_q      = (op == 2'b01);
    q_at_check = (qm == 0) ? exp_q : (qm == 2);
    match      = (q_at_check == exp_q);
    q_mode     = qm;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_before_cmd op=%0d got=%b want=1", op, req_ready);
    end
    req_valid = 1'b1;
    req_op    = op;
    req_len   = len;
    for (int n = 1; n <= T; n++) begin
      @(posedge clk); #1;
      es  = (op == 2'b01) && (n <= L);
      er  = (op == 2'b10) && (n <= L);
      ed  = (n == T) && ((op == 2'b00) || (is_sr && match));
      ee  = (n == T) && ((op == 2'b11) || (is_sr && !match));
      ery = (n == T);
      if (n == T && is_sr && !match && mis_model < 255) mis_model++;
      vectors++;
      if (s !== es) begin
        miscompares++;
        $display("FAIL cmd_s op=%0d len=%0d n=%0d got=%b want=%b", op, len, n, s, es);
      end
      vectors++;
      if (r !== er) begin
        miscompares++;
        $display("FAIL cmd_r op=%0d len=%0d n=%0d got=%b want=%b", op, len, n, r, er);
      end
      vectors++;
      if (done !== ed) begin
        miscompares++;
        $display("FAIL cmd_done op=%0d len=%0d n=%0d got=%b want=%b", op, len, n, done, ed);
      end
      vectors++;
      if (err !== ee) begin
        miscompares++;
        $display("FAIL cmd_err op=%0d len=%0d n=%0d got=%b want=%b", op, len, n, err, ee);
      end
      vectors++;
      if (req_ready !== ery) begin
        miscompares++;
        $display("FAIL cmd_ready op=%0d len=%0d n=%0d got=%b want=%b", op, len, n, req_ready, ery);
      end
      vectors++;
      if (mismatch_cnt !== 8'(mis_model)) begin
        miscompares++;
        $display("FAIL cmd_mismatch_cnt op=%0d n=%0d got=%0d want=%0d", op, n, mismatch_cnt, mis_model);
      end
      // While busy, junk on the request bus must be ignored
      if (n < T) begin
        req_valid = 1'($urandom_range(0, 1));
        req_op    = 2'($urandom);
        req_len   = 4'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_len   = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({s, r, done, err} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_outputs s,r,done,err got=%b want=0000", {s, r, done, err});
    end
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready got=%b want=0", req_ready);
    end
    vectors++;
    if (mismatch_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_mismatch_cnt got=%0d want=0", mismatch_cnt);
    end
    mis_model = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got=%b want=1", req_ready);
    end
  endtask

  task automatic test_set();
    run_cmd(2'b01, 4'd3, 0);
  endtask

  task automatic test_reset_mismatch();
    run_cmd(2'b10, 4'd0, 2);
  endtask

  task automatic test_hold_illegal();
    run_cmd(2'b11, 4'd5, 0);
    run_cmd(2'b00, 4'd2, 0);
    run_cmd(2'b11, 4'd0, 2);
  endtask

  task automatic test_abort();
    q_mode    = 0;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_len   = 4'd8;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int n = 2; n <= 3; n++) begin
      @(posedge clk); #1;
    end
    vectors++;
    if (s !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_drive_s got=%b want=1", s);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    mis_model = 0;
    vectors++;
    if ({s, r, done, err, req_ready} !== 5'b00000) begin
      miscompares++;
      $display("FAIL abort_outputs s,r,done,err,ready got=%b want=00000", {s, r, done, err, req_ready});
    end
    vectors++;
    if (mismatch_cnt !== 8'd0) begin
      miscompares++;
      $display("FAIL abort_mismatch_cnt got=%0d want=0", mismatch_cnt);
    end
    rst = 1'b0;
    for (int n = 1; n <= 15; n++) begin
      @(posedge clk); #1;
      vectors++;
      if ({s, r, done, err, req_ready} !== 5'b00001) begin
        miscompares++;
        $display("FAIL abort_quiet n=%0d s,r,done,err,ready got=%b want=00001", n, {s, r, done, err, req_ready});
      end
    end
  endtask

  task automatic test_rst_handshake();
    req_valid = 1'b1;
    req_op    = 2'b10;
    req_len   = 4'd2;
    rst       = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if ({s, r, req_ready} !== 3'b000) begin
      miscompares++;
      $display("FAIL rst_handshake s,r,ready got=%b want=000", {s, r, req_ready});
    end
    rst = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      vectors++;
      if ({s, r, done, err, req_ready} !== 5'b00001) begin
        miscompares++;
        $display("FAIL rst_handshake_drop n=%0d s,r,done,err,ready got=%b want=00001", n, {s, r, done, err, req_ready});
      end
    end
  endtask

  task automatic test_back_to_back_random();
    for (int i = 0; i < 150; i++) begin
      run_cmd(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 260; i++) begin
      run_cmd(2'b10, 4'd0, 2);
    end
    vectors++;
    if (mismatch_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation_cnt got=%0d want=255", mismatch_cnt);
    end
    run_cmd(2'b01, 4'd1, 0);
    run_cmd(2'b11, 4'd1, 0);
    vectors++;
    if (mismatch_cnt !== 8'd255) begin
      miscompares++;
      $display("FAIL saturation_hold got=%0d want=255", mismatch_cnt);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_set();
    test_reset_mismatch();
    test_hold_illegal();
    test_abort();
    test_rst_handshake();
    test_back_to_back_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
